operand_entry_controller: RTL and testbench

Upstream input stage for the 4-bit carry-lookahead adder display top. It turns one shared 4-bit switch bank plus a single load pushbutton into two registered operands `a` and `b`, which drive the adder and seven-segment display inputs directly. It synchronizes and debounces the button, detects presses, and steps a three-state entry FSM. It also flags when both operands are valid.

---
 rtl/operand_entry_controller.sv | 172 +++++++++++++++++
 tb/tb_operand_entry_controller.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/operand_entry_controller.sv
// -----------------------------------------------------------------------------
// operand_entry_controller
//
// Input stage for the 4-bit carry-lookahead adder display. One shared 4-bit
// switch bank and one load pushbutton are used to enter two registered
// operands. Each accepted button press captures the switches into the next
// operand in the sequence A, B, A, B, ...
//
// Ports
//   clk       in   system clock; all state updates on the rising edge
//   clr       in   synchronous active-high reset; overrides all other logic
//   sw[3:0]   in   operand switches (asynchronous, quasi-static)
//   btn_load  in   load pushbutton (asynchronous, bouncy, active-high)
//   a[3:0]    out  registered operand A
//   b[3:0]    out  registered operand B
//   valid     out  high while both a and b hold a completed entry pair
//   phase[1:0] out entry FSM state: WAIT_A=00, WAIT_B=01, SHOW=10
//
// Parameters
//   DB_CYCLES  cycles a synchronized level must persist to be accepted
//   CNT_W      debounce counter width; 2**CNT_W must exceed DB_CYCLES
//
// Configuration macro
//   OPERAND_DEBOUNCE_EN  defined:   counter-based debouncer is built
//                        undefined: debounced level is a one-cycle registered
//                                   copy of the synchronized button, and
//                                   DB_CYCLES / CNT_W have no effect
// -----------------------------------------------------------------------------
module operand_entry_controller #(
  parameter int unsigned DB_CYCLES = 1_000_000,
  parameter int unsigned CNT_W     = 20
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] sw,
  input  logic       btn_load,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic       valid,
  output logic [1:0] phase
);

  typedef enum logic [1:0] {
    WAIT_A  = 2'b00,
    WAIT_B  = 2'b01,
    SHOW    = 2'b10,
    ILLEGAL = 2'b11
  } state_e;

  // Refuse to elaborate a counter too narrow to ever reach DB_CYCLES-1.
  if ((64'd1 << CNT_W) <= 64'(DB_CYCLES)) begin : g_bad_cnt_w
    $error("CNT_W too small for DB_CYCLES");
  end

  // Two-flop synchronizers for the asynchronous inputs.
  logic       btn_meta_q, btn_meta_d;
  logic       btn_s_q,    btn_s_d;
  logic [3:0] sw_meta_q,  sw_meta_d;
  logic [3:0] sw_s_q,     sw_s_d;

  // Debounced level, its one-cycle history, and the press pulse.
  logic       btn_db_q,      btn_db_d;
  logic       btn_db_prev_q, btn_db_prev_d;
  logic       press_q,       press_d;

  // Entry FSM and operand registers.
  state_e     state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic       valid_q, valid_d;

`ifdef OPERAND_DEBOUNCE_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case/if tree can leave a signal unassigned and infer a latch.
    btn_meta_d    = btn_load;
    btn_s_d       = btn_meta_q;
    sw_meta_d     = sw;
    sw_s_d        = sw_meta_q;
    btn_db_prev_d = btn_db_q;
    // Rising edge of the debounced level, registered into a one-cycle pulse.
    press_d       = btn_db_q & ~btn_db_prev_q;
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    valid_d       = valid_q;

`ifdef OPERAND_DEBOUNCE_EN
    // The counter only runs while the synchronized level disagrees with the
    // accepted level; any agreement, even for one cycle, restarts it.
    btn_db_d = btn_db_q;
    cnt_d    = '0;
    if (btn_s_q != btn_db_q) begin
      if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
        btn_db_d = ~btn_db_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
`else
    btn_db_d = btn_s_q;
`endif

    unique case (state_q)
      WAIT_A: if (press_q) begin
        a_d     = sw_s_q;
        valid_d = 1'b0;
        state_d = WAIT_B;
      end
      WAIT_B: if (press_q) begin
        b_d     = sw_s_q;
        valid_d = 1'b1;
        state_d = SHOW;
      end
      // A press while showing a result starts a new pair; b keeps its old
      // value until the second press of the pair overwrites it.
      SHOW: if (press_q) begin
        a_d     = sw_s_q;
        valid_d = 1'b0;
        state_d = WAIT_B;
      end
      // Unreachable encoding: recover without touching the operands.
      ILLEGAL: state_d = WAIT_A;
      default: state_d = WAIT_A;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (clr) begin
      btn_meta_q    <= 1'b0;
      btn_s_q       <= 1'b0;
      sw_meta_q     <= 4'h0;
      sw_s_q        <= 4'h0;
      btn_db_q      <= 1'b0;
      btn_db_prev_q <= 1'b0;
      press_q       <= 1'b0;
      state_q       <= WAIT_A;
      a_q           <= 4'h0;
      b_q           <= 4'h0;
      valid_q       <= 1'b0;
`ifdef OPERAND_DEBOUNCE_EN
      cnt_q         <= '0;
`endif
    end else begin
      btn_meta_q    <= btn_meta_d;
      btn_s_q       <= btn_s_d;
      sw_meta_q     <= sw_meta_d;
      sw_s_q        <= sw_s_d;
      btn_db_q      <= btn_db_d;
      btn_db_prev_q <= btn_db_prev_d;
      press_q       <= press_d;
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      valid_q       <= valid_d;
`ifdef OPERAND_DEBOUNCE_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

  assign a     = a_q;
  assign b     = b_q;
  assign valid = valid_q;
  assign phase = state_q;

endmodule

// File: tb/tb_operand_entry_controller.sv
// -----------------------------------------------------------------------------
// tb_operand_entry_controller
//
// Directed self-checking bench for operand_entry_controller with DB_CYCLES=4.
// Expected values are hand-computed; press latency is DB_CYCLES+4 cycles with
// OPERAND_DEBOUNCE_EN defined and 5 cycles otherwise.
// -----------------------------------------------------------------------------
module tb_operand_entry_controller;

  localparam int unsigned DB = 4;
`ifdef OPERAND_DEBOUNCE_EN
  localparam int LAT = DB + 4;
`else
  localparam int LAT = 5;
`endif

  logic       clk = 1'b0;
  logic       clr;
  logic [3:0] sw;
  logic       btn_load;
  logic [3:0] a;
  logic [3:0] b;
  logic       valid;
  logic [1:0] phase;

  int n_checks = 0;
  int n_fail   = 0;

  operand_entry_controller #(
    .DB_CYCLES(DB),
    .CNT_W    (3)
  ) dut (
    .clk     (clk),
    .clr     (clr),
    .sw      (sw),
    .btn_load(btn_load),
    .a       (a),
    .b       (b),
    .valid   (valid),
    .phase   (phase)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] ea, input logic [3:0] eb,
                           input logic ev, input logic [1:0] ep);
    check({tag, ".a"},     32'(a),     32'(ea));
    check({tag, ".b"},     32'(b),     32'(eb));
    check({tag, ".valid"}, 32'(valid), 32'(ev));
    check({tag, ".phase"}, 32'(phase), 32'(ep));
  endtask

  initial begin
    // Reset with switches up and button idle.
    clr = 1'b1; sw = 4'hF; btn_load = 1'b0;
    tick(2);
    clr = 1'b0;
    check_all("reset", 4'h0, 4'h0, 1'b0, 2'b00);
    tick(20);
    check_all("idle", 4'h0, 4'h0, 1'b0, 2'b00);

    // First press loads A exactly LAT cycles after the button edge.
    sw = 4'h9; btn_load = 1'b1;
    tick(LAT - 1);
    check_all("a_early", 4'h0, 4'h0, 1'b0, 2'b00);
    tick(1);
    check_all("a_load", 4'h9, 4'h0, 1'b0, 2'b01);
    tick(10 - LAT);
    btn_load = 1'b0;
    tick(15);
    check_all("release", 4'h9, 4'h0, 1'b0, 2'b01);

    // Second press loads B and raises valid.
    sw = 4'h7; btn_load = 1'b1;
    tick(LAT);
    check_all("b_load", 4'h9, 4'h7, 1'b1, 2'b10);
    tick(10 - LAT);
    btn_load = 1'b0;
    tick(15);

    // Re-entry from SHOW: A reloads, B kept, valid drops.
    sw = 4'h3; btn_load = 1'b1;
    tick(LAT - 1);
    check_all("reent_early", 4'h9, 4'h7, 1'b1, 2'b10);
    tick(1);
    check_all("reent", 4'h3, 4'h7, 1'b0, 2'b01);
    tick(10 - LAT);
    btn_load = 1'b0;
    tick(15);

`ifdef OPERAND_DEBOUNCE_EN
    // Bounce: two 2-cycle pulses are rejected, the final hold is one press.
    sw = 4'h6;
    for (int i = 0; i < 2; i++) begin
      btn_load = 1'b1; tick(2);
      btn_load = 1'b0; tick(2);
    end
    btn_load = 1'b1;
    tick(LAT - 1);
    check_all("bounce_early", 4'h3, 4'h7, 1'b0, 2'b01);
    tick(1);
    check_all("bounce", 4'h3, 4'h6, 1'b1, 2'b10);
    tick(20);
    check_all("bounce_once", 4'h3, 4'h6, 1'b1, 2'b10);
    btn_load = 1'b0;
    tick(15);
`else
    // Without debouncing a single-cycle glitch is a press.
    sw = 4'hA; btn_load = 1'b1;
    tick(1);
    btn_load = 1'b0;
    tick(LAT - 1);
    check_all("glitch", 4'h3, 4'hA, 1'b1, 2'b10);
    tick(15);
    check_all("glitch_once", 4'h3, 4'hA, 1'b1, 2'b10);

    sw = 4'hC; btn_load = 1'b1;
    tick(LAT - 1);
    check_all("clean_early", 4'h3, 4'hA, 1'b1, 2'b10);
    tick(1);
    check_all("clean", 4'hC, 4'hA, 1'b0, 2'b01);
    btn_load = 1'b0;
    tick(15);
`endif

    // Reset mid-debounce with the button held: the press restarts from scratch.
    btn_load = 1'b1;
    tick(3);
    clr = 1'b1;
    tick(1);
    clr = 1'b0; sw = 4'h5;
    check_all("midrst", 4'h0, 4'h0, 1'b0, 2'b00);
    tick(LAT - 1);
    check_all("midrst_early", 4'h0, 4'h0, 1'b0, 2'b00);
    tick(1);
    check_all("midrst_load", 4'h5, 4'h0, 1'b0, 2'b01);
    btn_load = 1'b0;
    tick(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
